ddr_rw_arbiter: RTL and testbench

- Sits directly upstream of the DDR burst engine that drives the MIG app interface.
- Decides when to issue write bursts (draining the camera-side write FIFO) and read bursts (filling the display-side read FIFO).
- Generates frame-buffer addresses with frame wrap, and gates FIFO read/write enables from the burst engine's data handshakes.
- Exactly one burst is outstanding at a time; read and write requests are never asserted together.

---
 rtl/ddr_arb_pkg.sv | 19 +
 rtl/ddr_frame_addr_gen.sv | 67 ++++++
 rtl/ddr_rw_arbiter.sv | 150 +++++++++++++++
 tb/tb_ddr_rw_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// rtl/ddr_arb_pkg.sv - shared state encodings and address-step constants for the DDR read/write arbiter
package ddr_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE_WR = 3'd1,
        ST_WAIT_WR  = 3'd2,
        ST_ISSUE_RD = 3'd3,
        ST_WAIT_RD  = 3'd4
    } arb_state_e;

    // One 128-bit beat spans 8 app address units.
    localparam int BEAT_UNITS      = 8;
    localparam int DEF_BURST_LEN   = 64;
    localparam int DEF_FRAME_BEATS = 115200;
    localparam int BURST_STEP      = DEF_BURST_LEN * BEAT_UNITS;
    localparam int FRAME_SPAN      = DEF_FRAME_BEATS * BEAT_UNITS;

endpackage

// File: rtl/ddr_frame_addr_gen.sv
// rtl/ddr_frame_addr_gen.sv - per-channel frame offset, wrap detect, pending frame sync and buffer select
module ddr_frame_addr_gen
    import ddr_arb_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 28,
    parameter int                    STEP       = BURST_STEP,
    parameter int                    SPAN       = FRAME_SPAN,
    parameter logic [ADDR_WIDTH-1:0] BASE0      = '0,
    parameter logic [ADDR_WIDTH-1:0] BASE1      = '0
) (
    input  logic                  ui_clk,
    input  logic                  rst_n,
    input  logic                  busy_i,
    input  logic                  advance_i,
    input  logic                  sync_i,
    input  logic                  buf_load_i,
    input  logic                  buf_src_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  wrap_o,
    output logic                  apply_o,
    output logic                  buf_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP_A = ADDR_WIDTH'(STEP);
    localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(SPAN - STEP);

    logic [ADDR_WIDTH-1:0] off_q, off_d;
    logic                  pend_q, pend_d;
    logic                  buf_q, buf_d;
    logic                  pend_set;

    always_comb begin
        pend_set = pend_q | sync_i;
        wrap_o   = advance_i && (off_q == LAST_A);
        // A sync seen mid-burst waits for finish so the burst address never moves.
        apply_o  = pend_set && (advance_i || !busy_i);
        off_d    = off_q;
        pend_d   = pend_set;
        buf_d    = buf_q;
        if (advance_i) begin
            off_d = wrap_o ? '0 : off_q + STEP_A;
        end
        if (apply_o) begin
            off_d  = '0;
            pend_d = 1'b0;
        end
        if (buf_load_i) begin
            buf_d = buf_src_i;
        end
    end

    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            off_q  <= '0;
            pend_q <= 1'b0;
            buf_q  <= 1'b0;
        end else begin
            off_q  <= off_d;
            pend_q <= pend_d;
            buf_q  <= buf_d;
        end
    end

    assign buf_o  = buf_q;
    assign addr_o = (buf_q ? BASE1 : BASE0) + off_q;

endmodule

// File: rtl/ddr_rw_arbiter.sv
// rtl/ddr_rw_arbiter.sv - single-outstanding read/write burst arbiter with frame addressing; DDR_PINGPONG_EN enables double buffering
module ddr_rw_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 28,
    parameter int                    BURST_LEN   = DEF_BURST_LEN,
    parameter int                    FIFO_DEPTH  = 1024,
    parameter int                    FRAME_BEATS = DEF_FRAME_BEATS,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR0  = '0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR1  = ADDR_WIDTH'(32'h0200000)
) (
    input  logic                  ui_clk,
    input  logic                  rst_n,
    input  logic                  init_calib_complete,
    input  logic [10:0]           wr_fifo_rdcnt,
    output logic                  wr_fifo_rd_en,
    input  logic [10:0]           rd_fifo_wrcnt,
    output logic                  rd_fifo_wr_en,
    input  logic                  wr_frame_sync,
    input  logic                  rd_frame_sync,
    output logic                  wr_burst_req,
    output logic [9:0]            wr_burst_len,
    output logic [ADDR_WIDTH-1:0] wr_burst_addr,
    input  logic                  wr_burst_data_req,
    input  logic                  wr_burst_finish,
    output logic                  rd_burst_req,
    output logic [9:0]            rd_burst_len,
    output logic [ADDR_WIDTH-1:0] rd_burst_addr,
    input  logic                  rd_burst_data_valid,
    input  logic                  rd_burst_finish,
    output logic                  rd_frame_ready
);

    localparam int          STEP   = BURST_LEN * BEAT_UNITS;
    localparam int          SPAN   = FRAME_BEATS * BEAT_UNITS;
    localparam logic [10:0] WR_MIN = 11'(BURST_LEN);
    localparam logic [10:0] RD_MAX = 11'(FIFO_DEPTH - BURST_LEN);

    arb_state_e state_q, state_d;
    logic       last_rd_q, last_rd_d;
    logic       ready_q, ready_d;
    logic       wr_ok, rd_ok, wr_busy, rd_busy, wr_adv, rd_adv;
    logic       wr_wrap, wr_apply, rd_wrap, rd_apply, wr_buf, rd_buf;
    logic       wr_load, wr_src, rd_load, rd_src;

    assign wr_ok   = wr_fifo_rdcnt >= WR_MIN;
    assign rd_ok   = ready_q && (rd_fifo_wrcnt <= RD_MAX);
    assign wr_busy = (state_q == ST_ISSUE_WR) || (state_q == ST_WAIT_WR);
    assign rd_busy = (state_q == ST_ISSUE_RD) || (state_q == ST_WAIT_RD);

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        wr_adv    = 1'b0;
        rd_adv    = 1'b0;
        ready_d   = ready_q | wr_wrap;
        case (state_q)
            ST_IDLE: begin
                if (init_calib_complete) begin
                    if (wr_ok && (!rd_ok || last_rd_q)) begin
                        state_d = ST_ISSUE_WR;
                    end else if (rd_ok) begin
                        state_d = ST_ISSUE_RD;
                    end
                end
            end
            ST_ISSUE_WR: state_d = ST_WAIT_WR;
            ST_WAIT_WR: begin
                if (wr_burst_finish) begin
                    wr_adv    = 1'b1;
                    last_rd_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_ISSUE_RD: state_d = ST_WAIT_RD;
            ST_WAIT_RD: begin
                if (rd_burst_finish) begin
                    rd_adv    = 1'b1;
                    last_rd_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            last_rd_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            ready_q   <= ready_d;
        end
    end

`ifdef DDR_PINGPONG_EN
    // Buffer the writer just finished; the reader adopts it at its own frame boundary.
    logic wr_last_q;
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            wr_last_q <= 1'b0;
        end else if (wr_wrap) begin
            wr_last_q <= wr_buf;
        end
    end
    assign wr_load = wr_wrap;
    assign wr_src  = ~wr_buf;
    assign rd_load = rd_wrap | rd_apply;
    assign rd_src  = wr_last_q;
    logic unused_sig;
    assign unused_sig = ^{wr_apply, rd_buf};
`else
    assign wr_load = 1'b0;
    assign wr_src  = 1'b0;
    assign rd_load = 1'b0;
    assign rd_src  = 1'b0;
    logic unused_sig;
    assign unused_sig = ^{wr_apply, rd_buf, wr_buf, rd_wrap, rd_apply};
`endif

    ddr_frame_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .STEP(STEP), .SPAN(SPAN),
        .BASE0(BASE_ADDR0), .BASE1(BASE_ADDR1)
    ) u_wr_addr (
        .ui_clk(ui_clk), .rst_n(rst_n), .busy_i(wr_busy), .advance_i(wr_adv),
        .sync_i(wr_frame_sync), .buf_load_i(wr_load), .buf_src_i(wr_src),
        .addr_o(wr_burst_addr), .wrap_o(wr_wrap), .apply_o(wr_apply), .buf_o(wr_buf)
    );

    ddr_frame_addr_gen #(
        .ADDR_WIDTH(ADDR_WIDTH), .STEP(STEP), .SPAN(SPAN),
        .BASE0(BASE_ADDR0), .BASE1(BASE_ADDR1)
    ) u_rd_addr (
        .ui_clk(ui_clk), .rst_n(rst_n), .busy_i(rd_busy), .advance_i(rd_adv),
        .sync_i(rd_frame_sync), .buf_load_i(rd_load), .buf_src_i(rd_src),
        .addr_o(rd_burst_addr), .wrap_o(rd_wrap), .apply_o(rd_apply), .buf_o(rd_buf)
    );

    assign wr_burst_req   = (state_q == ST_ISSUE_WR);
    assign rd_burst_req   = (state_q == ST_ISSUE_RD);
    assign wr_burst_len   = 10'(BURST_LEN);
    assign rd_burst_len   = 10'(BURST_LEN);
    assign wr_fifo_rd_en  = wr_burst_data_req;
    assign rd_fifo_wr_en  = rd_burst_data_valid;
    assign rd_frame_ready = ready_q;

endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb/tb_ddr_rw_arbiter.sv - directed self-checking bench for ddr_rw_arbiter
module tb_ddr_rw_arbiter;

`ifdef DDR_PINGPONG_EN
    localparam logic [27:0] WR_BASE_B = 28'h0200000;
`else
    localparam logic [27:0] WR_BASE_B = 28'h0000000;
`endif

    logic        ui_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_calib_complete = 1'b0;
    logic [10:0] wr_fifo_rdcnt = '0;
    logic [10:0] rd_fifo_wrcnt = '0;
    logic        wr_frame_sync = 1'b0;
    logic        rd_frame_sync = 1'b0;
    logic        wr_burst_data_req = 1'b0;
    logic        wr_burst_finish = 1'b0;
    logic        rd_burst_data_valid = 1'b0;
    logic        rd_burst_finish = 1'b0;
    logic        wr_fifo_rd_en, rd_fifo_wr_en, wr_burst_req, rd_burst_req, rd_frame_ready;
    logic [9:0]  wr_burst_len, rd_burst_len;
    logic [27:0] wr_burst_addr, rd_burst_addr;

    int checks = 0;
    int errors = 0;

    ddr_rw_arbiter dut (
        .ui_clk(ui_clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
        .wr_fifo_rdcnt(wr_fifo_rdcnt), .wr_fifo_rd_en(wr_fifo_rd_en),
        .rd_fifo_wrcnt(rd_fifo_wrcnt), .rd_fifo_wr_en(rd_fifo_wr_en),
        .wr_frame_sync(wr_frame_sync), .rd_frame_sync(rd_frame_sync),
        .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
        .wr_burst_data_req(wr_burst_data_req), .wr_burst_finish(wr_burst_finish),
        .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len), .rd_burst_addr(rd_burst_addr),
        .rd_burst_data_valid(rd_burst_data_valid), .rd_burst_finish(rd_burst_finish),
        .rd_frame_ready(rd_frame_ready)
    );

    always #5 ui_clk = ~ui_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(output logic gw, output logic gr, output logic [27:0] a);
        gw = 1'b0;
        gr = 1'b0;
        a  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ui_clk);
            if (wr_burst_req || rd_burst_req) begin
                gw = wr_burst_req;
                gr = rd_burst_req;
                a  = wr_burst_req ? wr_burst_addr : rd_burst_addr;
                break;
            end
        end
        chk("req_exclusive", {31'b0, gw & gr}, 32'd0);
    endtask

    task automatic burst(input logic is_wr, input logic sync_mid, input string tag,
                         input logic [27:0] exp_addr);
        logic        gw, gr;
        logic [27:0] a;
        wait_req(gw, gr, a);
        chk({tag, "_grant"}, {31'b0, is_wr ? gw : gr}, 32'd1);
        chk({tag, "_addr"}, {4'b0, a}, {4'b0, exp_addr});
        @(negedge ui_clk);
        chk({tag, "_pulse"}, {31'b0, is_wr ? wr_burst_req : rd_burst_req}, 32'd0);
        chk({tag, "_hold"}, {4'b0, is_wr ? wr_burst_addr : rd_burst_addr}, {4'b0, exp_addr});
        if (sync_mid) begin
            wr_frame_sync = 1'b1;
            @(negedge ui_clk);
            wr_frame_sync = 1'b0;
        end
        if (is_wr) wr_burst_finish = 1'b1;
        else       rd_burst_finish = 1'b1;
        @(negedge ui_clk);
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
    endtask

    task automatic no_req(input string tag, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge ui_clk);
            seen = seen | wr_burst_req | rd_burst_req;
        end
        chk(tag, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        logic        gw, gr, seen;
        logic [27:0] a;

        repeat (3) @(negedge ui_clk);
        chk("rst_wr_req", {31'b0, wr_burst_req}, 32'd0);
        chk("rst_rd_req", {31'b0, rd_burst_req}, 32'd0);
        chk("rst_wr_addr", {4'b0, wr_burst_addr}, 32'd0);
        chk("rst_rd_addr", {4'b0, rd_burst_addr}, 32'd0);
        chk("rst_ready", {31'b0, rd_frame_ready}, 32'd0);
        chk("wr_len", {22'b0, wr_burst_len}, 32'd64);
        chk("rd_len", {22'b0, rd_burst_len}, 32'd64);

        wr_burst_data_req = 1'b1;
        #1;
        chk("wr_fifo_rd_en_hi", {31'b0, wr_fifo_rd_en}, 32'd1);
        chk("rd_fifo_wr_en_lo", {31'b0, rd_fifo_wr_en}, 32'd0);
        wr_burst_data_req   = 1'b0;
        rd_burst_data_valid = 1'b1;
        #1;
        chk("wr_fifo_rd_en_lo", {31'b0, wr_fifo_rd_en}, 32'd0);
        chk("rd_fifo_wr_en_hi", {31'b0, rd_fifo_wr_en}, 32'd1);
        rd_burst_data_valid = 1'b0;

        @(negedge ui_clk);
        rst_n         = 1'b1;
        wr_fifo_rdcnt = 11'd64;
        no_req("calib_gate", 5);

        init_calib_complete = 1'b1;
        burst(1'b1, 1'b0, "wr_only0", 28'h0);
        burst(1'b1, 1'b0, "wr_only1", 28'h200);

        wr_fifo_rdcnt = 11'd63;
        no_req("wr_below_burst", 5);

        wr_fifo_rdcnt = 11'd64;
        rd_fifo_wrcnt = 11'd961;
        burst(1'b1, 1'b1, "sync_mid", 28'h400);
        chk("sync_mid_next_addr", {4'b0, wr_burst_addr}, 32'd0);

        for (int b = 0; b < 1800; b++) begin
            burst(1'b1, 1'b0, "wrap", 28'(b * 512));
            if (b == 1798) chk("ready_before_wrap", {31'b0, rd_frame_ready}, 32'd0);
        end
        chk("ready_after_wrap", {31'b0, rd_frame_ready}, 32'd1);
        burst(1'b1, 1'b0, "wrap_next", WR_BASE_B);

        wr_fifo_rdcnt = 11'd0;
        no_req("rd_backpressure_961", 5);
        rd_fifo_wrcnt = 11'd960;
        seen = 1'b0;
        for (int i = 0; i < 2 && !seen; i++) begin
            @(negedge ui_clk);
            seen = rd_burst_req;
        end
        chk("rd_req_at_960", {31'b0, seen}, 32'd1);
        chk("rd_addr_first", {4'b0, rd_burst_addr}, 32'd0);
        @(negedge ui_clk);
        rd_burst_data_valid = 1'b1;
        #1;
        chk("rd_push_in_burst", {31'b0, rd_fifo_wr_en}, 32'd1);
        rd_burst_data_valid = 1'b0;
        rd_burst_finish     = 1'b1;
        @(negedge ui_clk);
        rd_burst_finish = 1'b0;

        wr_fifo_rdcnt = 11'd100;
        rd_fifo_wrcnt = 11'd0;
        burst(1'b1, 1'b0, "rr0_wr", WR_BASE_B + 28'h200);
        burst(1'b0, 1'b0, "rr1_rd", 28'h200);
        burst(1'b1, 1'b0, "rr2_wr", WR_BASE_B + 28'h400);
        burst(1'b0, 1'b0, "rr3_rd", 28'h400);

        wr_fifo_rdcnt = 11'd0;
        wait_req(gw, gr, a);
        chk("rst_test_rd_grant", {31'b0, gr}, 32'd1);
        chk("rst_test_rd_addr", {4'b0, a}, 32'h600);
        @(negedge ui_clk);
        rst_n               = 1'b0;
        init_calib_complete = 1'b0;
        @(negedge ui_clk);
        chk("midrst_wr_req", {31'b0, wr_burst_req}, 32'd0);
        chk("midrst_rd_req", {31'b0, rd_burst_req}, 32'd0);
        chk("midrst_wr_addr", {4'b0, wr_burst_addr}, 32'd0);
        chk("midrst_rd_addr", {4'b0, rd_burst_addr}, 32'd0);
        chk("midrst_ready", {31'b0, rd_frame_ready}, 32'd0);
        rst_n         = 1'b1;
        wr_fifo_rdcnt = 11'd64;
        no_req("post_rst_idle", 3);
        init_calib_complete = 1'b1;
        burst(1'b1, 1'b0, "post_rst_wr", 28'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
